// File: rtl/mdr_engine_pkg.sv
// Shared types for the iterative multiply / divide / square-root engine.
package mdr_engine_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } mdr_state_e;

  localparam int MDR_N_DEFAULT = 8;

endpackage

// File: rtl/mdr_step.sv
// One combinational iteration of Booth multiply, restoring divide or restoring square root.
module mdr_step import mdr_engine_pkg::*; #(
  parameter int N = MDR_N_DEFAULT
) (
  input  op_e            op_i,
  input  logic [N+1:0]   a_i,
  input  logic [N-1:0]   q_i,
  input  logic           qm1_i,
  input  logic [N+1:0]   m_i,
  input  logic [N/2-1:0] root_i,
  output logic [N+1:0]   a_o,
  output logic [N-1:0]   q_o,
  output logic           qm1_o,
  output logic [N/2-1:0] root_o
);

  logic [N+1:0] booth_sum;
  logic [N+1:0] div_sh;
  logic [N+1:0] div_trial;
  logic [N+1:0] sq_sh;
  logic [N+1:0] sq_trial;
  logic [N+1:0] sq_diff;

  always_comb begin
    booth_sum = a_i;
    case ({q_i[0], qm1_i})
      2'b01:   booth_sum = a_i + m_i;
      2'b10:   booth_sum = a_i - m_i;
      default: booth_sum = a_i;
    endcase
  end

  assign div_sh    = {a_i[N:0], q_i[N-1]};
  assign div_trial = div_sh - m_i;

  // Two radicand bits enter the partial remainder; trial is {root, 01}.
  assign sq_sh    = {a_i[N-1:0], q_i[N-1:N-2]};
  assign sq_trial = {{(N/2){1'b0}}, root_i, 2'b01};
  assign sq_diff  = sq_sh - sq_trial;

  always_comb begin
    a_o    = a_i;
    q_o    = q_i;
    qm1_o  = qm1_i;
    root_o = root_i;
    case (op_i)
      OP_MUL: begin
        a_o   = {booth_sum[N+1], booth_sum[N+1:1]};
        q_o   = {booth_sum[0], q_i[N-1:1]};
        qm1_o = q_i[0];
      end
      OP_DIV: begin
        q_o = {q_i[N-2:0], ~div_trial[N+1]};
        a_o = div_trial[N+1] ? div_sh : div_trial;
      end
      OP_SQRT: begin
        q_o = {q_i[N-3:0], 2'b00};
        if (sq_diff[N+1]) begin
          a_o    = sq_sh;
          root_o = {root_i[N/2-2:0], 1'b0};
        end else begin
          a_o    = sq_diff;
          root_o = {root_i[N/2-2:0], 1'b1};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdr_engine.sv
// Iterative MUL/DIV/SQRT engine: A/Q/M registers, iteration counter and control FSM.
// Define MDR_SIGNED_DIV_EN for two's-complement division (magnitude divide plus sign fix-up).
module mdr_engine import mdr_engine_pkg::*; #(
  parameter int N = MDR_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   data_x,
  input  logic [N-1:0]   data_y,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [2*N-1:0] result
);

  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  mdr_state_e     state_q;
  op_e            op_q;
  logic [N-1:0]   x_q, y_q;
  logic [N+1:0]   a_q, m_q;
  logic [N-1:0]   q_q;
  logic           qm1_q;
  logic [H-1:0]   root_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q, err_q;
  logic [2*N-1:0] res_q;

  logic [N+1:0]   a_d;
  logic [N-1:0]   q_d;
  logic           qm1_d;
  logic [H-1:0]   root_d;
  logic [2*N-1:0] res_d;
  logic           err_d;
  logic [N-1:0]   div_x, div_y;

`ifdef MDR_SIGNED_DIV_EN
  logic quo_neg_q, rem_neg_q, ovf_q;
  logic ovf_load;

  assign div_x    = x_q[N-1] ? -x_q : x_q;
  assign div_y    = y_q[N-1] ? -y_q : y_q;
  // Most-negative / -1 has no representable positive quotient.
  assign ovf_load = (x_q == {1'b1, {(N-1){1'b0}}}) && (&y_q);
`else
  assign div_x = x_q;
  assign div_y = y_q;
`endif

  mdr_step #(.N(N)) u_step (
    .op_i   (op_q),
    .a_i    (a_q),
    .q_i    (q_q),
    .qm1_i  (qm1_q),
    .m_i    (m_q),
    .root_i (root_q),
    .a_o    (a_d),
    .q_o    (q_d),
    .qm1_o  (qm1_d),
    .root_o (root_d)
  );

  // Result as it will look after the final RUN step.
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (op_q)
      OP_MUL:  res_d = {a_d[N-1:0], q_d};
      OP_DIV: begin
`ifdef MDR_SIGNED_DIV_EN
        res_d = {(rem_neg_q ? -a_d[N-1:0] : a_d[N-1:0]),
                 (quo_neg_q ? -q_d : q_d)};
        err_d = ovf_q;
`else
        res_d = {a_d[N-1:0], q_d};
`endif
      end
      OP_SQRT: res_d = {a_d[N-1:0], {(N-H){1'b0}}, root_d};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
`ifdef MDR_SIGNED_DIV_EN
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            x_q     <= data_x;
            y_q     <= data_y;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          a_q     <= '0;
          qm1_q   <= 1'b0;
          root_q  <= '0;
          cnt_q   <= CNT_FULL;
          q_q     <= y_q;
          m_q     <= {{2{x_q[N-1]}}, x_q};
          state_q <= RUN;
          case (op_q)
            OP_DIV: begin
              q_q <= div_x;
              m_q <= {2'b00, div_y};
`ifdef MDR_SIGNED_DIV_EN
              quo_neg_q <= x_q[N-1] ^ y_q[N-1];
              rem_neg_q <= x_q[N-1];
              ovf_q     <= ovf_load;
`endif
              if (y_q == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                res_q   <= {x_q, {N{1'b1}}};
              end
            end
            OP_SQRT: begin
              q_q   <= x_q;
              m_q   <= '0;
              cnt_q <= CNT_HALF;
            end
            OP_BAD: begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              res_q   <= '0;
            end
            default: ;
          endcase
        end
        RUN: begin
          a_q    <= a_d;
          q_q    <= q_d;
          qm1_q  <= qm1_d;
          root_q <= root_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            res_q   <= res_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = err_q;
  assign result = res_q;

endmodule

// File: tb/tb_mdr_engine.sv
// Self-checking bench for mdr_engine (N=8): vector table plus scoreboard, then control corner cases.
module tb_mdr_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  data_x = 8'h00;
  logic [7:0]  data_y = 8'h00;
  logic        busy, done, error;
  logic [15:0] result;

  mdr_engine #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .data_x (data_x),
    .data_y (data_y),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] res;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one operation; the expected outcome goes to the scoreboard and is
  // popped when done pulses. poke_run re-asserts start in that RUN cycle,
  // poke_done asserts start for exactly the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] er, input logic ee, input int el,
                        input int poke_run, input bit poke_done);
    sb_t e;
    int  cyc;
    bit  seen;
    @(negedge clk);
    op = o; data_x = x; data_y = y; start = 1'b1;
    sb_q.push_back('{er, ee, el});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_in_load", busy, 1);
      end
      if (poke_run > 0 && cyc == poke_run) begin
        start = 1'b1; op = 2'b01; data_x = 8'hAA; data_y = 8'h03;
      end
      if (poke_run > 0 && cyc == poke_run + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles, expected at %0d", cyc, el);
      void'(sb_q.pop_back());
    end else begin
      e = sb_q.pop_front();
      check("result", {16'h0, result}, {16'h0, e.res});
      check("error", {31'h0, error}, {31'h0, e.err});
      check("latency", cyc, e.lat);
      check("busy_at_done", {31'h0, busy}, 32'h0);
    end
    if (poke_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int extra;

    vecs.push_back('{2'b00, 8'hFD, 8'h07, 16'hFFEB, 1'b0, 10});
    vecs.push_back('{2'b00, 8'h80, 8'h80, 16'h4000, 1'b0, 10});
    vecs.push_back('{2'b00, 8'h7F, 8'h81, 16'hC0FF, 1'b0, 10});
    vecs.push_back('{2'b11, 8'h12, 8'h34, 16'h0000, 1'b1, 2});
    vecs.push_back('{2'b00, 8'h03, 8'h04, 16'h000C, 1'b0, 10});
    vecs.push_back('{2'b01, 8'd100, 8'd7, 16'h020E, 1'b0, 10});
    vecs.push_back('{2'b01, 8'd55, 8'd0, 16'h37FF, 1'b1, 2});
`ifdef MDR_SIGNED_DIV_EN
    vecs.push_back('{2'b01, 8'h9C, 8'h07, 16'hFEF2, 1'b0, 10});
    vecs.push_back('{2'b01, 8'h80, 8'hFF, 16'h0080, 1'b1, 10});
`else
    vecs.push_back('{2'b01, 8'd200, 8'd3, 16'h0242, 1'b0, 10});
    vecs.push_back('{2'b01, 8'hFF, 8'h01, 16'h00FF, 1'b0, 10});
`endif
    vecs.push_back('{2'b10, 8'd200, 8'h00, 16'h040E, 1'b0, 6});
    vecs.push_back('{2'b10, 8'd255, 8'h00, 16'h1E0F, 1'b0, 6});
    vecs.push_back('{2'b10, 8'd0, 8'h00, 16'h0000, 1'b0, 6});
    vecs.push_back('{2'b10, 8'd16, 8'h00, 16'h0004, 1'b0, 6});

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].err, vecs[i].lat, 0, 1'b0);

    // Start during RUN and during the done cycle: neither may launch another op.
    run_op(2'b00, 8'h05, 8'h06, 16'h001E, 1'b0, 10, 4, 1'b1);
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("ignored_start_no_done", extra, 0);
    check("ignored_start_idle_busy", {31'h0, busy}, 32'h0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    op = 2'b00; data_x = 8'h7F; data_y = 8'h7F; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_rst", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", {31'h0, busy}, 32'h0);
    check("midrun_rst_done", {31'h0, done}, 32'h0);
    check("midrun_rst_result", {16'h0, result}, 32'h0);
    check("midrun_rst_error", {31'h0, error}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 8'h03, 8'h04, 16'h000C, 1'b0, 10, 0, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
